uart_xmitter: RTL and testbench

- Single-channel 8N1 UART transmitter for board bring-up.
- A byte is presented on switches (i_data_in) and a load strobe (i_data_DV) starts transmission of one frame on a serial GPIO line (o_tx).
- Busy is flagged on o_wait. The accepted byte is echoed on o_data_in for LEDs; a 4-bit state code is exported on debug.

---
 rtl/uart_xmitter.sv | 161 ++++++++++++++++
 tb/tb_uart_xmitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmitter.sv
// uart_xmitter: single-channel 8N1 UART transmitter for board bring-up.
// A rising edge on i_data_DV while idle latches i_data_in and sends one frame
// (start, 8 data bits LSB first, stop) on o_tx, each bit CLKS_PER_BIT clocks.
// Optional macro UART_XMITTER_PARITY_EN inserts an even-parity bit before stop.
`timescale 1ns/1ps
module uart_xmitter #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data_in,
  input  logic       i_data_DV,
  output logic [7:0] o_data_in,
  output logic       o_tx,
  output logic       o_wait,
  output logic [3:0] debug
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA   = 4'd2,
    STOP   = 4'd3
`ifdef UART_XMITTER_PARITY_EN
    ,
    PARITY = 4'd4
`endif
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_n;
  logic [15:0] baud_q, baud_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  shreg_q, shreg_n;
  logic [7:0]  echo_n;
  logic        tx_n, wait_n;
  logic        dv_d;
  logic        start_req;
  logic        baud_done;
  logic        accept;

  assign start_req = i_data_DV & ~dv_d;
  assign baud_done = (baud_q == BAUD_LAST);
  assign debug     = state_q;

  // State, counters, data and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      o_data_in <= '0;
      o_tx      <= 1'b1;
      o_wait    <= 1'b0;
      dv_d      <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_q     <= bit_n;
      shreg_q   <= shreg_n;
      o_data_in <= echo_n;
      o_tx      <= tx_n;
      o_wait    <= wait_n;
      dv_d      <= i_data_DV;
    end
  end

  // Next-state and counter logic; line outputs are decoded from the next state
  // so they are registered alongside the FSM without an extra cycle of lag.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    echo_n  = o_data_in;
    accept  = 1'b0;
    tx_n    = 1'b1;
    wait_n  = 1'b1;

    case (state_q)
      IDLE: begin
        accept = start_req;
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_XMITTER_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
`ifdef UART_XMITTER_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = IDLE;
          // The edge that re-enters IDLE may itself accept a new request.
          accept  = start_req;
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase

    if (accept) begin
      shreg_n = i_data_in;
      echo_n  = i_data_in;
      baud_n  = '0;
      bit_n   = '0;
      state_n = START;
    end

    case (state_n)
      IDLE:   wait_n = 1'b0;
      START:  tx_n   = 1'b0;
      DATA:   tx_n   = shreg_n[bit_n];
`ifdef UART_XMITTER_PARITY_EN
      PARITY: tx_n   = ^shreg_n;
`endif
      STOP:   tx_n   = 1'b1;
      default: begin
        tx_n   = 1'b1;
        wait_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_xmitter.sv
// Self-checking bench for uart_xmitter: two instances (CLKS_PER_BIT 1 and 4)
// share stimulus and are compared every cycle against a frame-queue model.
`timescale 1ns/1ps
module tb_uart_xmitter;

`ifdef UART_XMITTER_PARITY_EN
  localparam int NBITS = 11;
  localparam int TBL_N = 12;
`else
  localparam int NBITS = 10;
  localparam int TBL_N = 11;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] echo1, echo4;
  logic       tx1, tx4, w1, w4;
  logic [3:0] dbg1, dbg4;

  always #5 clk = ~clk;

  uart_xmitter #(.CLKS_PER_BIT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(din), .i_data_DV(dv),
    .o_data_in(echo1), .o_tx(tx1), .o_wait(w1), .debug(dbg1)
  );

  uart_xmitter #(.CLKS_PER_BIT(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(din), .i_data_DV(dv),
    .o_data_in(echo4), .o_tx(tx4), .o_wait(w4), .debug(dbg4)
  );

  int checks = 0;
  int errors = 0;
  int wcnt1 = 0;
  int wcnt4 = 0;

  typedef struct {
    logic       tx;
    logic [3:0] dbg;
  } samp_t;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       tx;
    logic       w;
    logic [3:0] dbg;
  } vec_t;

  samp_t      q1[$];
  samp_t      q4[$];
  logic [7:0] m_echo1 = 8'h00;
  logic [7:0] m_echo4 = 8'h00;
  logic       m_pdv = 1'b0;

  // Line level of bit-time j of a frame carrying d.
  function automatic logic frame_lvl(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9 && NBITS == 11) return ^d;
    return 1'b1;
  endfunction

  // State code expected during bit-time j.
  function automatic logic [3:0] frame_code(input int j);
    if (j == 0) return 4'd1;
    if (j <= 8) return 4'd2;
    if (j == 9 && NBITS == 11) return 4'd4;
    return 4'd3;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, advance model, compare after posedge.
  task automatic step(input logic v, input logic [7:0] d);
    samp_t      s;
    logic       sreq;
    logic       etx1, etx4, ew1, ew4;
    logic [3:0] ed1, ed4;
    @(negedge clk);
    dv   = v;
    din  = d;
    sreq = v & ~m_pdv;
    m_pdv = v;
    if (sreq && q1.size() == 0) begin
      m_echo1 = d;
      for (int j = 0; j < NBITS; j++) begin
        s.tx = frame_lvl(d, j); s.dbg = frame_code(j);
        q1.push_back(s);
      end
    end
    if (sreq && q4.size() == 0) begin
      m_echo4 = d;
      for (int j = 0; j < NBITS; j++)
        for (int r = 0; r < 4; r++) begin
          s.tx = frame_lvl(d, j); s.dbg = frame_code(j);
          q4.push_back(s);
        end
    end
    if (q1.size() > 0) begin s = q1.pop_front(); etx1 = s.tx; ew1 = 1'b1; ed1 = s.dbg; end
    else begin etx1 = 1'b1; ew1 = 1'b0; ed1 = 4'd0; end
    if (q4.size() > 0) begin s = q4.pop_front(); etx4 = s.tx; ew4 = 1'b1; ed4 = s.dbg; end
    else begin etx4 = 1'b1; ew4 = 1'b0; ed4 = 4'd0; end
    @(posedge clk);
    #1;
    if (w1) wcnt1++;
    if (w4) wcnt4++;
    chk("tx1",   8'(tx1),  8'(etx1));
    chk("wait1", 8'(w1),   8'(ew1));
    chk("dbg1",  8'(dbg1), 8'(ed1));
    chk("echo1", echo1,    m_echo1);
    chk("tx4",   8'(tx4),  8'(etx4));
    chk("wait4", 8'(w4),   8'(ew4));
    chk("dbg4",  8'(dbg4), 8'(ed4));
    chk("echo4", echo4,    m_echo4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 100) begin
      step(1'b0, 8'h00);
      n++;
    end
    if (q1.size() != 0 || q4.size() != 0)
      chk("idle_bound", 8'(q1.size() + q4.size()), 8'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx1"},   8'(tx1),  8'd1);
    chk({tag, "_wait1"}, 8'(w1),   8'd0);
    chk({tag, "_echo1"}, echo1,    8'h00);
    chk({tag, "_dbg1"},  8'(dbg1), 8'd0);
    chk({tag, "_tx4"},   8'(tx4),  8'd1);
    chk({tag, "_wait4"}, 8'(w4),   8'd0);
    chk({tag, "_echo4"}, echo4,    8'h00);
    chk({tag, "_dbg4"},  8'(dbg4), 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[TBL_N];
    // A5 frame on the CLKS_PER_BIT=1 instance, one row per cycle after the edge.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 4'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd2};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd2};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd2};
`ifdef UART_XMITTER_PARITY_EN
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd4};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd3};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
`else
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd3};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
`endif

    // Reset: low at 2 ns for 4 ns.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_low");
    #3 rst_n = 1'b1;
    #1 chk_reset_outputs("rst_rel");

    // Table-driven single frame.
    for (int i = 0; i < TBL_N; i++) begin
      step(tbl[i].dv, tbl[i].d);
      chk("tbl_tx",   8'(tx1),  8'(tbl[i].tx));
      chk("tbl_wait", 8'(w1),   8'(tbl[i].w));
      chk("tbl_dbg",  8'(dbg1), 8'(tbl[i].dbg));
    end
    chk("tbl_echo", echo1, 8'hA5);
    wait_idle();

    // Busy rejection: second request mid-frame is dropped.
    step(1'b1, 8'h3C);
    repeat (3) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    wait_idle();
    repeat (5) step(1'b0, 8'h00);
    chk("busy_echo1", echo1, 8'h3C);
    chk("busy_echo4", echo4, 8'h3C);

    // Held strobe gives exactly one frame.
    wcnt1 = 0; wcnt4 = 0;
    repeat (30) step(1'b1, 8'h01);
    wait_idle();
    repeat (10) step(1'b0, 8'h00);
    chk("held_wait1_cycles", 8'(wcnt1), 8'(NBITS));
    chk("held_wait4_cycles", 8'(wcnt4), 8'(4 * NBITS));

    // 0x80 at four clocks per bit.
    wcnt1 = 0; wcnt4 = 0;
    step(1'b1, 8'h80);
    wait_idle();
    chk("b80_wait4_cycles", 8'(wcnt4), 8'(4 * NBITS));

    // Reset in the middle of a frame aborts it.
    step(1'b1, 8'h5A);
    repeat (5) step(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    q1.delete(); q4.delete();
    m_echo1 = 8'h00; m_echo4 = 8'h00; m_pdv = 1'b0;
    dv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // Sweep of byte values with idle gaps.
    for (int b = 0; b < 255; b++) begin
      step(1'b1, b[7:0]);
      wait_idle();
      repeat (12) step(1'b0, 8'h00);
    end

    // Random strobes and data, including back-to-back and mid-frame requests.
    repeat (1500) step($urandom_range(0, 3) == 0, 8'($urandom));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
